// File: rtl/stream_packer_if.sv
// stream_packer_if: input and output stream handshakes of stream_packer.
//   in*  : producer side, left-justified lanes plus a per-word lane count
//   out* : sink side, densely packed lanes plus a lane count
// The slave modport is the packer's view; the master modport is the environment's view.
interface stream_packer_if #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 8
);
  localparam int unsigned LANES = WIDTH / SHIFTBITS_PER_STEP;
  localparam int unsigned CW    = $clog2(LANES) + 1;

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic [CW-1:0]    inCount;
  logic             inLast;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData;
  logic [CW-1:0]    outCount;
  logic             outLast;

  modport slave (
    input  inValid, inData, inCount, inLast, outReady,
    output inReady, outValid, outData, outCount, outLast
  );

  modport master (
    output inValid, inData, inCount, inLast, outReady,
    input  inReady, outValid, outData, outCount, outLast
  );
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs words that carry a variable number of left-justified
// lanes into dense full words, plus a partial final word at packet end.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : stream_packer_if.slave (inValid/inReady/inData/inCount/inLast,
//           outValid/outReady/outData/outCount/outLast)
module stream_packer #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 8
) (
  input logic            clk,
  input logic            reset,
  stream_packer_if.slave bus
);
  localparam int unsigned LW    = SHIFTBITS_PER_STEP;
  localparam int unsigned LANES = WIDTH / LW;
  localparam int unsigned CW    = $clog2(LANES) + 1;
  localparam int unsigned FW    = $clog2(LANES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           r_state;
  logic [FW-1:0]    r_fill;
  logic [WIDTH-1:0] r_hold;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_count;
  logic             r_out_last;

  logic             w_slot_free;
  logic             w_accept;
  logic [CW-1:0]    w_cnt;
  logic [CW-1:0]    w_sum;
  logic [CW-1:0]    w_over;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_merged;

  state_t           w_state_nxt;
  logic [FW-1:0]    w_fill_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_data;
  logic [CW-1:0]    w_ld_count;
  logic             w_ld_last;

  // Zero every lane at index >= n.
  function automatic logic [WIDTH-1:0] keep_lanes(input logic [WIDTH-1:0] d,
                                                  input logic [CW-1:0]    n);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      if (CW'(j) < n) r[j*LW +: LW] = d[j*LW +: LW];
    end
    return r;
  endfunction

  assign w_slot_free = !r_out_valid || bus.outReady;
  assign bus.inReady = !reset && (r_state == RUN) && w_slot_free;
  assign w_accept    = bus.inValid && bus.inReady;

  assign w_cnt  = (bus.inCount > CW'(LANES)) ? CW'(LANES) : bus.inCount;
  assign w_sum  = CW'(r_fill) + w_cnt;
  assign w_over = w_sum - CW'(LANES);

  // Left-rotate by the fill level: output lane j takes input lane (j - F) mod LANES,
  // then lanes below F come from the hold register.
  always_comb begin
    w_rot    = '0;
    w_merged = '0;
    for (int j = 0; j < LANES; j++) begin
      w_rot[j*LW +: LW] = bus.inData[int'(FW'(FW'(j) - r_fill))*LW +: LW];
    end
    for (int j = 0; j < LANES; j++) begin
      w_merged[j*LW +: LW] = (CW'(j) < CW'(r_fill)) ? r_hold[j*LW +: LW]
                                                    : w_rot[j*LW +: LW];
    end
  end

  // Next state, hold/fill update and output-word production.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_hold_nxt  = r_hold;
    w_load      = 1'b0;
    w_ld_data   = '0;
    w_ld_count  = '0;
    w_ld_last   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          if (bus.inLast && (w_sum <= CW'(LANES))) begin
            // Packet ends within this word, possibly with zero lanes.
            w_load     = 1'b1;
            w_ld_data  = keep_lanes(w_merged, w_sum);
            w_ld_count = w_sum;
            w_ld_last  = 1'b1;
            w_fill_nxt = '0;
            w_hold_nxt = '0;
          end else if (w_sum >= CW'(LANES)) begin
            // Full word out; the rotated tail wraps into the low hold lanes.
            w_load     = 1'b1;
            w_ld_data  = w_merged;
            w_ld_count = CW'(LANES);
            w_ld_last  = 1'b0;
            w_hold_nxt = keep_lanes(w_rot, w_over);
            w_fill_nxt = FW'(w_over);
            if (bus.inLast) w_state_nxt = FLUSH;
          end else begin
            w_hold_nxt = keep_lanes(w_merged, w_sum);
            w_fill_nxt = FW'(w_sum);
          end
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_ld_data   = r_hold;
          w_ld_count  = CW'(r_fill);
          w_ld_last   = 1'b1;
          w_fill_nxt  = '0;
          w_hold_nxt  = '0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State, hold and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_fill  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Output register: a new word replaces a draining one without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ld_data;
      r_out_count <= w_ld_count;
      r_out_last  <= w_ld_last;
    end else if (bus.outReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.outValid = r_out_valid;
  assign bus.outData  = r_out_data;
  assign bus.outCount = r_out_count;
  assign bus.outLast  = r_out_last;
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: bench for stream_packer with LANES=4, 8-bit lanes.
module tb_stream_packer;
  localparam int WIDTH = 32;
  localparam int LW    = 8;
  localparam int LANES = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;

  stream_packer_if #(.WIDTH(WIDTH), .SHIFTBITS_PER_STEP(LW)) bus ();

  stream_packer #(.WIDTH(WIDTH), .SHIFTBITS_PER_STEP(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic [CW-1:0] cnt;
    logic          last;
  } word_t;

  typedef struct {
    logic [31:0]   d;
    logic [CW-1:0] n;
    logic          l;
    bit            emit;
    logic [31:0]   ed;
    logic [CW-1:0] ec;
    logic          el;
  } vec_t;

  word_t exp_q[$];
  byte   mq[$];
  int    checks    = 0;
  int    failures  = 0;
  int    cyc       = 0;
  bit    rnd_mode  = 0;
  int    out_lasts = 0;
  int    in_lasts  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    word_t e;
    if (!reset && bus.outValid && bus.outReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual data=0x%0h cnt=%0d last=%0d required none",
                 bus.outData, bus.outCount, bus.outLast);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.outData, e.data);
        check("out_count", 32'(bus.outCount), 32'(e.cnt));
        check("out_last", 32'(bus.outLast), 32'(e.last));
      end
      if (bus.outLast) out_lasts++;
    end
  end

  // Random outReady while in random mode.
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 bus.outReady = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [CW-1:0] n, input logic l);
    word_t w;
    w.data = d;
    w.cnt  = n;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic push_model_word(input int n, input logic l);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i*8 +: 8] = mq.pop_front();
    w.cnt  = CW'(n);
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Lane-queue reference: append lanes, emit full words, close packets on last.
  task automatic model_accept(input logic [31:0] d, input logic [CW-1:0] n, input logic l);
    int c;
    c = (int'(n) > LANES) ? LANES : int'(n);
    for (int i = 0; i < c; i++) mq.push_back(d[i*8 +: 8]);
    if (l) begin
      while (mq.size() > LANES) push_model_word(LANES, 1'b0);
      push_model_word(mq.size(), 1'b1);
    end else if (mq.size() >= LANES) begin
      push_model_word(LANES, 1'b0);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [CW-1:0] n, input logic l,
                      input bit use_model);
    int waited;
    bit ok;
    waited = 0;
    ok     = 0;
    bus.inValid = 1'b1;
    bus.inData  = d;
    bus.inCount = n;
    bus.inLast  = l;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = bus.inReady;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=0x%0h", d);
    end else if (use_model) begin
      model_accept(d, n, l);
    end
    bus.inValid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t        tbl[10];
    int          t0;
    logic [31:0] d;
    logic [CW-1:0] n;
    logic        l;

    tbl[0] = '{32'h00CCBBAA, 3'd3, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[1] = '{32'h0000EEDD, 3'd2, 1'b0, 1'b1, 32'hDDCCBBAA, 3'd4, 1'b0};
    tbl[2] = '{32'h000000FF, 3'd1, 1'b1, 1'b1, 32'h0000FFEE, 3'd2, 1'b1};
    tbl[3] = '{32'h00000000, 3'd0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[4] = '{32'h00000000, 3'd0, 1'b1, 1'b1, 32'h00000000, 3'd0, 1'b1};
    tbl[5] = '{32'h44332211, 3'd7, 1'b0, 1'b1, 32'h44332211, 3'd4, 1'b0};
    tbl[6] = '{32'h999999AA, 3'd1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[8] = '{32'h7777CCBB, 3'd2, 1'b1, 1'b1, 32'h00CCBBAA, 3'd3, 1'b1};
    tbl[9] = '{32'hD4C3B2A1, 3'd4, 1'b1, 1'b1, 32'hD4C3B2A1, 3'd4, 1'b1};

    reset        = 1'b1;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.inCount  = '0;
    bus.inLast   = 1'b0;
    bus.outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.outValid), 32'd0);
    check("rst_out_data", bus.outData, 32'd0);
    check("rst_out_count", 32'(bus.outCount), 32'd0);
    check("rst_out_last", 32'(bus.outLast), 32'd0);
    check("rst_in_ready", 32'(bus.inReady), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(bus.inReady), 32'd1);

    // Table: merge, degenerate counts, clamping, ignored upper lanes.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].emit) push_exp(tbl[i].ed, tbl[i].ec, tbl[i].el);
      send(tbl[i].d, tbl[i].n, tbl[i].l, 1'b0);
    end
    wait_drain();

    // Overflow on last: one FLUSH bubble.
    push_exp(32'h44332211, 3'd4, 1'b0);
    push_exp(32'h00000055, 3'd1, 1'b1);
    send(32'h00332211, 3'd3, 1'b0, 1'b0);
    send(32'h00005544, 3'd2, 1'b1, 1'b0);
    check("flush_in_ready_low", 32'(bus.inReady), 32'd0);
    @(posedge clk);
    #1;
    check("flush_in_ready_back", 32'(bus.inReady), 32'd1);
    wait_drain();

    // Backpressure: held word stays stable, input stalls.
    bus.outReady = 1'b0;
    push_exp(32'hA3A2A1A0, 3'd4, 1'b0);
    send(32'hA3A2A1A0, 3'd4, 1'b0, 1'b0);
    bus.inValid = 1'b1;
    bus.inData  = 32'hB3B2B1B0;
    bus.inCount = 3'd4;
    bus.inLast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.outValid), 32'd1);
      check("bp_out_data", bus.outData, 32'hA3A2A1A0);
      check("bp_out_count", 32'(bus.outCount), 32'd4);
      check("bp_out_last", 32'(bus.outLast), 32'd0);
      check("bp_in_ready", 32'(bus.inReady), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.outReady = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      d = 32'hB3B2B1B0 + 32'(k) * 32'h10101010;
      push_exp(d, 3'd4, 1'b0);
      send(d, 3'd4, 1'b0, 1'b0);
    end
    check("stream_cycles", 32'(cyc - t0), 32'd4);
    wait_drain();

    // Reset with F=2 and a held output word.
    send(32'h00002211, 3'd2, 1'b0, 1'b0);
    bus.outReady = 1'b0;
    send(32'h88776655, 3'd4, 1'b0, 1'b0);
    check("pre_rst_out_valid", 32'(bus.outValid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.outValid), 32'd0);
    check("mid_rst_out_data", bus.outData, 32'd0);
    check("mid_rst_out_count", 32'(bus.outCount), 32'd0);
    check("mid_rst_out_last", 32'(bus.outLast), 32'd0);
    check("mid_rst_in_ready", 32'(bus.inReady), 32'd0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.outReady = 1'b1;
    push_exp(32'h44332211, 3'd4, 1'b0);
    send(32'h44332211, 3'd4, 1'b0, 1'b0);
    wait_drain();

    // Random counts, lasts, gaps and outReady against the lane-queue model.
    mq.delete();
    out_lasts = 0;
    in_lasts  = 0;
    rnd_mode  = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      d = $urandom;
      n = CW'($urandom_range(0, 7));
      l = (k == 299) || ($urandom_range(0, 3) == 0);
      if (l) in_lasts++;
      send(d, n, l, 1'b1);
    end
    wait_drain();
    rnd_mode = 0;
    @(posedge clk);
    #2;
    bus.outReady = 1'b1;
    check("last_count", 32'(out_lasts), 32'(in_lasts));
    check("model_empty", 32'(mq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
